// File: rtl/corePckg.sv
// Shared types and constants for the core front end.
// Fetch FSM states, buffered fetch entries and the NOP encoding.
package corePckg;

    localparam int cXLEN = 32;

    localparam logic [cXLEN-1:0] cNopInst = 32'h0000_0013;

    typedef enum logic {
        eFetchRun,
        eFetchFlush
    } tFetchState;

    typedef struct packed {
        logic [cXLEN-1:0] inst;
        logic [cXLEN-1:0] pc;
    } tFetchEntry;

    function automatic logic [cXLEN-1:0] align_pc(
        input logic [cXLEN-1:0] a
    );
        return a & ~cXLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with synchronous flush, full/empty and count.
// Depth need not be a power of two; pointers wrap explicitly.
module fetch_fifo #(
    parameter  int Depth = 2,
    parameter  int Width = 32,
    localparam int CW    = $clog2(Depth + 1),
    localparam int PW    = $clog2(Depth)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [Width-1:0] wdata,
    input  logic             pop,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PW-1:0]    rd_q, rd_d;
    logic [PW-1:0]    wr_q, wr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        if (p == PW'(Depth - 1)) return '0;
        return p + PW'(1);
    endfunction

    assign full    = (cnt_q == CW'(Depth));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign rdata   = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = wdata;
                wr_d        = inc(wr_q);
            end
            if (do_pop) rd_d = inc(rd_q);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    // The credit check upstream must make this impossible.
    always @(posedge clk) begin
        if (!rst && !flush) assert (!(push && full && !do_pop));
    end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, credit-limited memory requests, response buffer,
// and a registered one-instruction output stage toward the decoder.
module inst_fetch
    import corePckg::*;
#(
    parameter logic [cXLEN-1:0] cResetPc   = 32'h0000_0000,
    parameter int               cFifoDepth = 2
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iStall,
    input  logic             iRedirect,
    input  logic [cXLEN-1:0] iRedirectPc,
    output logic             oMemReq,
    output logic [cXLEN-1:0] oMemAddr,
    input  logic             iMemGnt,
    input  logic             iMemRdv,
    input  logic [cXLEN-1:0] iMemRdata,
    output logic [cXLEN-1:0] oInst,
    output logic [cXLEN-1:0] oCurPc,
    output logic             oDv
);

    localparam int CW = $clog2(cFifoDepth + 1);
    localparam int UW = CW + 1;

    tFetchState       state_q, state_d;
    logic [cXLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]    discard_q, discard_d;
    logic [cXLEN-1:0] inst_q, inst_d;
    logic [cXLEN-1:0] cur_pc_q, cur_pc_d;
    logic             dv_q, dv_d;

    logic [UW-1:0]    used;
    logic             mem_req, grant, rsp_ok;
    logic             take_fifo, bypass;
    logic             aq_full, aq_empty;
    logic [CW-1:0]    aq_cnt;
    logic [cXLEN-1:0] aq_rdata;
    logic             dq_full, dq_empty, dq_push;
    logic [CW-1:0]    dq_cnt;
    tFetchEntry       dq_wdata, dq_rdata;

    // aq_cnt is the in-flight count: one queued address per granted request.
    assign used    = UW'(aq_cnt) + UW'(dq_cnt);
    assign mem_req = !iRst && (state_q == eFetchRun) && !iRedirect
                  && !aq_full && !dq_full
                  && (used < UW'(cFifoDepth));
    assign grant   = mem_req && iMemGnt;
    assign rsp_ok  = iMemRdv && (state_q == eFetchRun)
                  && !iRedirect && !aq_empty;

    assign take_fifo = !iStall && !dq_empty;
    assign bypass    = !iStall && dq_empty && rsp_ok;
    assign dq_push   = rsp_ok && !bypass;
    assign dq_wdata  = '{inst: iMemRdata, pc: aq_rdata};

    fetch_fifo #(
        .Depth(cFifoDepth),
        .Width(cXLEN)
    ) u_addr_q (
        .clk  (iClk),
        .rst  (iRst),
        .flush(iRedirect),
        .push (grant),
        .wdata(pc_q),
        .pop  (rsp_ok),
        .rdata(aq_rdata),
        .full (aq_full),
        .empty(aq_empty),
        .count(aq_cnt)
    );

    fetch_fifo #(
        .Depth(cFifoDepth),
        .Width($bits(tFetchEntry))
    ) u_data_q (
        .clk  (iClk),
        .rst  (iRst),
        .flush(iRedirect),
        .push (dq_push),
        .wdata(dq_wdata),
        .pop  (take_fifo),
        .rdata(dq_rdata),
        .full (dq_full),
        .empty(dq_empty),
        .count(dq_cnt)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        inst_d    = inst_q;
        cur_pc_d  = cur_pc_q;
        dv_d      = dv_q;

        if (!iStall) begin
            if (take_fifo) begin
                inst_d   = dq_rdata.inst;
                cur_pc_d = dq_rdata.pc;
                dv_d     = 1'b1;
            end else if (bypass) begin
                inst_d   = iMemRdata;
                cur_pc_d = aq_rdata;
                dv_d     = 1'b1;
            end else begin
                inst_d = cNopInst;
                dv_d   = 1'b0;
            end
        end

        if (grant) pc_d = pc_q + cXLEN'(4);

        case (state_q)
            eFetchRun: begin
                if (iRedirect) begin
                    // A response in the redirect cycle is already dropped.
                    discard_d = aq_cnt - CW'(iMemRdv);
                    if (discard_d != '0) state_d = eFetchFlush;
                end
            end
            eFetchFlush: begin
                if (iMemRdv && discard_q != '0)
                    discard_d = discard_q - CW'(1);
                if (discard_d == '0) state_d = eFetchRun;
            end
            default: state_d = eFetchRun;
        endcase

        if (iRedirect) begin
            pc_d = align_pc(iRedirectPc);
            dv_d = 1'b0;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= eFetchRun;
            pc_q      <= cResetPc;
            discard_q <= '0;
            inst_q    <= cNopInst;
            cur_pc_q  <= cResetPc;
            dv_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
            inst_q    <= inst_d;
            cur_pc_q  <= cur_pc_d;
            dv_q      <= dv_d;
        end
    end

    assign oMemReq  = mem_req;
    assign oMemAddr = pc_q;
    assign oInst    = inst_q;
    assign oCurPc   = cur_pc_q;
    assign oDv      = dv_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: streaming/stall table, grant hold-off,
// redirects with and without a same-cycle response, and PC wrap.
module tb_inst_fetch;
    import corePckg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] rpc = '0;
    logic        gnt = 1'b0;
    logic        rdv = 1'b0;
    logic [31:0] rdata = '0;

    logic        m_req, m_dv;
    logic [31:0] m_addr, m_inst, m_pc;
    logic        w_req, w_dv;
    logic [31:0] w_addr, w_inst, w_pc;

    always #5 clk = ~clk;

    inst_fetch #(
        .cResetPc  (32'h0000_0000),
        .cFifoDepth(2)
    ) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iStall     (stall),
        .iRedirect  (redir),
        .iRedirectPc(rpc),
        .oMemReq    (m_req),
        .oMemAddr   (m_addr),
        .iMemGnt    (gnt),
        .iMemRdv    (rdv),
        .iMemRdata  (rdata),
        .oInst      (m_inst),
        .oCurPc     (m_pc),
        .oDv        (m_dv)
    );

    inst_fetch #(
        .cResetPc  (32'hFFFF_FFF8),
        .cFifoDepth(4)
    ) wdut (
        .iClk       (clk),
        .iRst       (rst),
        .iStall     (stall),
        .iRedirect  (redir),
        .iRedirectPc(rpc),
        .oMemReq    (w_req),
        .oMemAddr   (w_addr),
        .iMemGnt    (1'b1),
        .iMemRdv    (1'b0),
        .iMemRdata  (32'h0000_0000),
        .oInst      (w_inst),
        .oCurPc     (w_pc),
        .oDv        (w_dv)
    );

    typedef struct {
        logic        stall;
        logic        gnt;
        logic        req;
        logic [31:0] addr;
        logic        dv;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl[16];
    logic [31:0] wexp_addr[5];
    logic        wexp_req[5];

    int          n_run;
    int          n_fail;
    int          cyc;
    int          lat;
    logic [31:0] pq_addr[$];
    int          pq_due[$];
    logic        hs;
    logic [31:0] hs_addr;

    function automatic logic [31:0] memw(input logic [31:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    function automatic vec_t mk(input logic s, input logic g,
                                input logic rq, input logic [31:0] ad,
                                input logic d, input logic [31:0] p);
        vec_t v;
        v.stall = s; v.gnt = g; v.req = rq;
        v.addr = ad; v.dv = d; v.pc = p;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic dv,
                           input logic [31:0] pc);
        chk({nm, ".dv"}, 32'(m_dv), 32'(dv));
        chk({nm, ".inst"}, m_inst, dv ? memw(pc) : cNopInst);
        if (dv) chk({nm, ".pc"}, m_pc, pc);
    endtask

    // Called at the negedge: capture the handshake, step one clock and
    // let the memory model present any response that is due.
    task automatic adv();
        hs = m_req && gnt;
        hs_addr = m_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (hs) begin
            pq_addr.push_back(hs_addr);
            pq_due.push_back(cyc + lat - 1);
        end
        rdv = 1'b0;
        rdata = '0;
        if (pq_due.size() > 0 && pq_due[0] <= cyc) begin
            rdv = 1'b1;
            rdata = memw(pq_addr[0]);
            void'(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end
    endtask

    task automatic do_reset(input int l);
        rst = 1'b1;
        stall = 1'b0;
        redir = 1'b0;
        gnt = 1'b0;
        rdv = 1'b0;
        rdata = '0;
        lat = l;
        pq_addr.delete();
        pq_due.delete();
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        n_run = 0;
        n_fail = 0;
        cyc = 0;
        lat = 1;

        tbl[0]  = mk(1'b0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
        tbl[1]  = mk(1'b0, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
        tbl[2]  = mk(1'b0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00);
        tbl[3]  = mk(1'b0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04);
        tbl[4]  = mk(1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
        tbl[5]  = mk(1'b0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C);
        tbl[6]  = mk(1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10);
        tbl[7]  = mk(1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h10);
        tbl[8]  = mk(1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h10);
        tbl[9]  = mk(1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h10);
        tbl[10] = mk(1'b1, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h10);
        tbl[11] = mk(1'b0, 1'b1, 1'b0, 32'h1C, 1'b1, 32'h10);
        tbl[12] = mk(1'b0, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14);
        tbl[13] = mk(1'b0, 1'b1, 1'b1, 32'h20, 1'b1, 32'h18);
        tbl[14] = mk(1'b0, 1'b1, 1'b1, 32'h24, 1'b1, 32'h1C);
        tbl[15] = mk(1'b0, 1'b1, 1'b1, 32'h28, 1'b1, 32'h20);

        wexp_addr[0] = 32'hFFFF_FFF8; wexp_req[0] = 1'b1;
        wexp_addr[1] = 32'hFFFF_FFFC; wexp_req[1] = 1'b1;
        wexp_addr[2] = 32'h0000_0000; wexp_req[2] = 1'b1;
        wexp_addr[3] = 32'h0000_0004; wexp_req[3] = 1'b1;
        wexp_addr[4] = 32'h0000_0008; wexp_req[4] = 1'b0;

        // Reset values, sampled while reset is held.
        @(negedge clk);
        chk("rst.req", 32'(m_req), 32'h0);
        chk("rst.addr", m_addr, 32'h0);
        chk("rst.dv", 32'(m_dv), 32'h0);
        chk("rst.inst", m_inst, cNopInst);
        chk("rst.pc", m_pc, 32'h0);
        chk("rst.wreq", 32'(w_req), 32'h0);
        chk("rst.waddr", w_addr, 32'hFFFF_FFF8);
        chk("rst.wpc", w_pc, 32'hFFFF_FFF8);
        chk("rst.wdv", 32'(w_dv), 32'h0);

        // Streaming with a 5-cycle stall in the middle.
        do_reset(1);
        for (int i = 0; i < 16; i++) begin
            stall = tbl[i].stall;
            gnt = tbl[i].gnt;
            @(negedge clk);
            chk($sformatf("row%0d.req", i), 32'(m_req), 32'(tbl[i].req));
            chk($sformatf("row%0d.addr", i), m_addr, tbl[i].addr);
            chk_out($sformatf("row%0d", i), tbl[i].dv, tbl[i].pc);
            if (i < 5) begin
                chk($sformatf("wrap%0d.req", i), 32'(w_req),
                    32'(wexp_req[i]));
                chk($sformatf("wrap%0d.addr", i), w_addr, wexp_addr[i]);
            end
            adv();
        end
        stall = 1'b0;

        // Grant withheld for cycles 4..7.
        do_reset(1);
        for (int c = 0; c < 11; c++) begin
            gnt = !(c >= 4 && c <= 7);
            @(negedge clk);
            if (c >= 4 && c <= 7) begin
                chk($sformatf("hold%0d.req", c), 32'(m_req), 32'h1);
                chk($sformatf("hold%0d.addr", c), m_addr, 32'h10);
            end
            if (c == 5) chk_out("hold5", 1'b1, 32'h0C);
            if (c == 6 || c == 7)
                chk_out($sformatf("hold%0d", c), 1'b0, 32'h0);
            if (c == 10) chk_out("hold10", 1'b1, 32'h10);
            adv();
        end

        // Redirect with two requests in flight and no same-cycle response.
        do_reset(3);
        gnt = 1'b1;
        for (int c = 0; c < 10; c++) begin
            redir = (c == 2);
            rpc = 32'h0000_0103;
            @(negedge clk);
            if (c >= 2 && c <= 4)
                chk($sformatf("rdA%0d.req", c), 32'(m_req), 32'h0);
            if (c == 5) begin
                chk("rdA5.req", 32'(m_req), 32'h1);
                chk("rdA5.addr", m_addr, 32'h0000_0100);
            end
            if (c >= 3 && c <= 8)
                chk($sformatf("rdA%0d.dv", c), 32'(m_dv), 32'h0);
            if (c == 9) chk_out("rdA9", 1'b1, 32'h0000_0100);
            adv();
        end
        redir = 1'b0;

        // Redirect in the same cycle as a response: one discard only.
        do_reset(2);
        gnt = 1'b1;
        for (int c = 0; c < 11; c++) begin
            redir = (c == 5);
            rpc = 32'h0000_0200;
            @(negedge clk);
            if (c == 4) chk_out("rdB4", 1'b1, 32'h04);
            if (c == 5) chk("rdB5.rdv", 32'(rdv), 32'h1);
            if (c == 5 || c == 6)
                chk($sformatf("rdB%0d.req", c), 32'(m_req), 32'h0);
            if (c == 7) begin
                chk("rdB7.req", 32'(m_req), 32'h1);
                chk("rdB7.addr", m_addr, 32'h0000_0200);
            end
            if (c >= 6 && c <= 9)
                chk($sformatf("rdB%0d.dv", c), 32'(m_dv), 32'h0);
            if (c == 10) chk_out("rdB10", 1'b1, 32'h0000_0200);
            adv();
        end
        redir = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
